// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, fixed latency.
// Optional macro DIV_ZERO_DETECT_EN short-circuits a zero divisor straight to DONE.
module seq_divider #(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_work;       // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_busy;
   logic             r_done;

   // The shifted partial remainder needs WIDTH+1 bits; after the restore step it
   // is always below 2^WIDTH, so only WIDTH bits are kept between steps.
   logic [WIDTH:0]   w_part;
   logic [WIDTH:0]   w_diff;
   logic             w_qbit;
   logic [WIDTH-1:0] w_next_rem;
   logic [WIDTH-1:0] w_next_work;
   logic             w_last;

   assign w_part      = {r_rem, r_work[WIDTH-1]};
   assign w_diff      = w_part - {1'b0, r_div};
   assign w_qbit      = ~w_diff[WIDTH];
   assign w_next_rem  = w_qbit ? w_diff[WIDTH-1:0] : w_part[WIDTH-1:0];
   assign w_next_work = {r_work[WIDTH-2:0], w_qbit};
   assign w_last      = (r_count == CW'(1));

`ifdef DIV_ZERO_DETECT_EN
   logic r_dbz;
   assign DivByZero = r_dbz;
`else
   assign DivByZero = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_work      <= '0;
         r_div       <= '0;
         r_rem       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
         r_dbz       <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (Start) begin
                  r_div   <= Divisor;
                  r_work  <= Dividend;
                  r_rem   <= '0;
                  r_count <= CW'(WIDTH);
`ifdef DIV_ZERO_DETECT_EN
                  if (Divisor == '0) begin
                     r_quotient  <= '1;
                     r_remainder <= Dividend;
                     r_dbz       <= 1'b1;
                     r_done      <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_busy  <= 1'b1;
                     r_state <= S_RUN;
                  end
`else
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
`endif
               end
            end
            S_RUN: begin
               r_rem   <= w_next_rem;
               r_work  <= w_next_work;
               r_count <= r_count - CW'(1);
               if (w_last) begin
                  r_quotient  <= w_next_work;
                  r_remainder <= w_next_rem;
`ifdef DIV_ZERO_DETECT_EN
                  r_dbz       <= 1'b0;
`endif
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign Quotient  = r_quotient;
   assign Remainder = r_remainder;
   assign Busy      = r_busy;
   assign Done      = r_done;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand and result bit width (legal values 2..16).
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port Start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 SHALL have port Dividend, input, WIDTH bits: unsigned numerator, captured when Start is accepted.
REQ-006 SHALL have port Divisor, input, WIDTH bits: unsigned denominator, captured when Start is accepted.
REQ-007 SHALL have port Quotient, output, WIDTH bits: registered result.
REQ-008 SHALL have port Remainder, output, WIDTH bits: registered result.
REQ-009 SHALL have port Busy, output, 1 bit: high while in RUN.
REQ-010 SHALL have port Done, output, 1 bit: single-cycle pulse marking valid results.
REQ-011 SHALL have port DivByZero, output, 1 bit: high with Done when the captured Divisor was 0.

Function
REQ-012 SHALL implement unsigned restoring division: Dividend = Quotient*Divisor + Remainder, with Remainder < Divisor whenever Divisor != 0.
REQ-013 SHALL use three states, IDLE, RUN and DONE, with IDLE as the reset state.
REQ-014 In IDLE, with Start=1 at edge k, SHALL capture both operands, load the iteration counter with WIDTH, and enter RUN at edge k.
REQ-015 In RUN, each edge SHALL perform one step: shift the partial remainder left, bringing in the next dividend MSB; trial-subtract the divisor; keep the difference and set the quotient bit to 1 if it is non-negative, else restore and set it to 0.
REQ-016 The partial remainder SHALL be WIDTH+1 bits wide so the trial subtraction never overflows.
REQ-017 After WIDTH steps (edge k+WIDTH), SHALL update Quotient and Remainder and enter DONE.
REQ-018 In DONE, Done SHALL be 1 for exactly one cycle; the next edge SHALL return the block to IDLE.
REQ-019 Busy SHALL be 1 exactly in RUN; Done and Busy SHALL never be high together.
REQ-020 Total latency SHALL be fixed: Done is high during the cycle after edge k+WIDTH.
REQ-021 Start SHALL be ignored in RUN and DONE; operand changes after capture SHALL NOT affect the running operation.
REQ-022 Quotient, Remainder and DivByZero SHALL hold their values from Done until the next accepted operation completes.
REQ-023 For Divisor=0 in the iterative path, results SHALL be Quotient = all ones and Remainder = Dividend (natural restoring behaviour).
REQ-024 Start held high continuously SHALL start a new operation on every return to IDLE, i.e. back-to-back every WIDTH+2 cycles.

Reset
REQ-025 Reset=1 at any edge SHALL force IDLE and clear Quotient, Remainder, Busy, Done, DivByZero and all internal registers to 0.
REQ-026 Reset SHALL take priority over Start.
REQ-027 An operation interrupted by Reset SHALL be abandoned, and Done SHALL NOT be produced for it.

Configuration
REQ-028 Macro DIV_ZERO_DETECT_EN: when defined, a captured Divisor of 0 SHALL skip RUN, go directly from IDLE to DONE at edge k, set Quotient = all ones, Remainder = Dividend and DivByZero = 1, with Done high during the cycle after edge k.
REQ-029 When DIV_ZERO_DETECT_EN is undefined, divide-by-zero SHALL run the full WIDTH-step path per REQ-023, and DivByZero SHALL be constant 0.

Verification
REQ-030 WIDTH=4, Dividend=13, Divisor=3, Start pulse -> Busy for 4 cycles, then Done pulse with Quotient=4, Remainder=1.
REQ-031 Dividend=15, Divisor=1 -> Quotient=15, Remainder=0; Dividend=5, Divisor=7 -> Quotient=0, Remainder=5.
REQ-032 Dividend=9, Divisor=0 -> Quotient=15, Remainder=9; with the macro, Done 1 cycle after Start and DivByZero=1; without it, Done after 4 RUN cycles and DivByZero=0.
REQ-033 Start with 13/3, then Start with 6/2 and changed operands during RUN -> single Done with Quotient=4, Remainder=1; second request ignored.
REQ-034 Reset asserted at the second RUN cycle -> no Done; all outputs 0 next cycle; a following 8/2 request yields Quotient=4, Remainder=0.
REQ-035 Exhaustive sweep of all 256 WIDTH=4 operand pairs against a reference model -> REQ-012 holds and latency matches REQ-020 (or REQ-028 for zero divisors).
